// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package  : if_stage_pkg
// Desc     : Shared constants, state encoding and helpers for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  localparam logic [4:0]  EXC_NONE         = 5'h00;
  localparam logic [4:0]  EXC_ADEL         = 5'h04;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  // REQ: request on the bus, WAIT: awaiting response, HOLD: slot buffered
  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_t;

  function automatic logic is_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Desc     : Instruction fetch stage. Owns one instruction slot at fetch_pc,
//            fetches it over a req/addr_ok/data_ok SRAM handshake and hands
//            it to decode. Handles delayed branch redirects, exception
//            flushes and misaligned-PC (AdEL) slots.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DE_enable,
  output logic        IF_ready,
  output logic [31:0] inst_out,
  output logic [31:0] IF_PC,
  output logic [4:0]  exccode_out,
  input  logic        PC_modified,
  input  logic [31:0] PC_modified_data,
  input  logic        exc_flush,
  input  logic [31:0] exc_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  if_state_t   r_state;
  if_state_t   w_state_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_redir_target;
  logic [31:0] r_inst;
  logic [4:0]  r_exccode;
  logic        r_cancel;
  logic        r_redir_pend;
  logic        r_req_active;   // request shown last cycle was not yet accepted

  logic        w_req;
  logic        w_ready;
  logic        w_handoff;
  logic        w_adel_slot;
  logic        w_capture;

  // Next-state and handshake decode; a request once shown is held until accepted
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_ready      = 1'b0;
    w_handoff    = 1'b0;
    w_adel_slot  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IF_REQ: begin
        if (r_req_active || is_aligned(r_fetch_pc)) begin
          w_req = 1'b1;
          if (inst_sram_addr_ok) w_state_next = IF_WAIT;
        end else if (!exc_flush) begin
          w_adel_slot  = 1'b1;
          w_state_next = IF_HOLD;
        end
      end
      IF_WAIT: begin
        if (inst_sram_data_ok) begin
          if (r_cancel || exc_flush) begin
            w_state_next = IF_REQ;
          end else begin
            w_capture    = 1'b1;
            w_state_next = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        w_ready   = !exc_flush;
        w_handoff = w_ready && DE_enable;
        if (exc_flush || w_handoff) w_state_next = IF_REQ;
      end
      default: w_state_next = IF_REQ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IF_REQ;
    else        r_state <= w_state_next;
  end

  // PC, redirect, cancel and instruction-slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc     <= RESET_PC;
      r_req_addr     <= RESET_PC;
      r_redir_target <= 32'h0;
      r_inst         <= 32'h0;
      r_exccode      <= EXC_NONE;
      r_cancel       <= 1'b0;
      r_redir_pend   <= 1'b0;
      r_req_active   <= 1'b0;
    end else begin
      // Latch the shown address so fetch_pc may move under a pending request
      if (w_req && !inst_sram_addr_ok) begin
        r_req_active <= 1'b1;
        r_req_addr   <= inst_sram_addr;
      end else begin
        r_req_active <= 1'b0;
      end

      if (exc_flush) begin
        r_fetch_pc   <= exc_target;
        r_redir_pend <= 1'b0;
      end else if (w_handoff) begin
        r_fetch_pc   <= PC_modified  ? PC_modified_data :
                        r_redir_pend ? r_redir_target   :
                                       r_fetch_pc + 32'd4;
        r_redir_pend <= 1'b0;
      end else if (PC_modified) begin
        r_redir_pend   <= 1'b1;
        r_redir_target <= PC_modified_data;
      end

      // A response for a flushed request is dropped when it finally arrives
      if (r_state == IF_WAIT && inst_sram_data_ok) begin
        r_cancel <= 1'b0;
      end else if (exc_flush && (r_state == IF_WAIT || w_req)) begin
        r_cancel <= 1'b1;
      end

      if (w_capture) begin
        r_inst    <= inst_sram_rdata;
        r_exccode <= EXC_NONE;
      end else if (w_adel_slot) begin
        r_inst    <= 32'h0;
        r_exccode <= EXC_ADEL;
      end
    end
  end

  assign inst_sram_req  = w_req && rst_n;
  assign inst_sram_addr = r_req_active ? r_req_addr : r_fetch_pc;
  assign IF_ready       = w_ready;
  assign inst_out       = r_inst;
  assign IF_PC          = r_fetch_pc;
  assign exccode_out    = r_exccode;

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch pipeline stage, directly upstream of the decode stage.
- Holds the fetch PC and issues one instruction-SRAM request at a time over a req/addr_ok/data_ok handshake.
- Buffers one fetched instruction and hands it to decode through an IF_ready/DE_enable handshake.
- Applies branch redirects after the delay slot, applies exception/eret flushes immediately, and flags misaligned fetch PCs as AdEL.

Parameters:
- RESET_PC, 32'hbfc00000, fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- DE_enable  in  1  decode can accept an instruction this cycle
- IF_ready  out  1  instruction, PC and exccode outputs are valid
- inst_out  out  32  fetched instruction
- IF_PC  out  32  PC of inst_out
- exccode_out  out  5  5'h00 none, 5'h04 AdEL(IF)
- PC_modified  in  1  branch/jump leaving decode; target follows the delay slot
- PC_modified_data  in  32  branch/jump target
- exc_flush  in  1  exception or eret commit; discard everything
- exc_target  in  32  handler or EPC address
- inst_sram_req  out  1  request valid
- inst_sram_addr  out  32  request address
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  response valid this cycle
- inst_sram_rdata  in  32  response data

Behaviour:
- Reset (async, rst_n=0):
  - state=REQ, fetch_pc=RESET_PC, cancel=0, redir_pend=0.
  - inst_out=0, exccode_out=0, IF_ready=0, inst_sram_req=0 while rst_n=0.
- States:
  - REQ: inst_sram_req=1, addr=fetch_pc.
  - WAIT: awaiting data_ok.
  - HOLD: instruction buffered.
- IF owns exactly one instruction slot, the instruction at fetch_pc. IF_PC=fetch_pc.
- REQ:
  - If fetch_pc[1:0]!=0: no request issued; next state HOLD with inst_out=0, exccode=5'h04.
  - Otherwise req stays high with a stable addr until addr_ok, then state goes to WAIT.
- WAIT: on data_ok with cancel=0, latch rdata into inst_out, set exccode=0, go to HOLD. Latency from data_ok to IF_ready is 1 cycle.
- IF_ready = (state==HOLD) & !exc_flush.
- Handoff (IF_ready & DE_enable):
  - fetch_pc <= PC_modified ? PC_modified_data : redir_pend ? redir_target : fetch_pc+4.
  - Clear redir_pend; state goes to REQ.
- PC_modified without handoff: redir_pend<=1, redir_target<=PC_modified_data. The owned instruction is the delay slot and is kept.
- exc_flush has priority over everything:
  - fetch_pc<=exc_target, redir_pend<=0.
  - HOLD: go to REQ.
  - WAIT with no data_ok this cycle: cancel<=1.
  - REQ with a request in progress: keep req/addr until addr_ok, set cancel, go to WAIT. The address is never changed mid-handshake.
  - The issued address remains in an internal req_addr register so that fetch_pc may change.
  - WAIT with data_ok in the same cycle: drop the data, go to REQ.
- Cancelled response: when data_ok arrives with cancel=1, drop the data, clear cancel, go to REQ at the current fetch_pc. Repeated flushes only update fetch_pc.
- Misaligned exc_target or PC_modified_data: becomes fetch_pc and produces the AdEL slot, with no SRAM access.
- fetch_pc+4 wraps modulo 2^32.
- data_ok outside WAIT is ignored. At most one outstanding request.

Decomposition:
- Shared package:
  - EXC_ADEL=5'h04, EXC_NONE=5'h00.
  - RESET_PC default.
  - State encoding localparams IF_REQ/IF_WAIT/IF_HOLD.
- No sub-module is needed; a single module.

Test Plan:
- Reset release with addr_ok and data_ok each 1 cycle later:
  - Addresses bfc00000, bfc00004 and bfc00008 are requested in order.
  - IF_ready pulses with the matching IF_PC while DE_enable=1.
- Backpressure:
  - DE_enable=0 for 5 cycles while in HOLD at bfc00004: IF_ready stays 1, inst_out stays stable, req stays 0.
  - Then DE_enable=1: the next request is bfc00008.
- Branch at bfc00010 leaves decode with PC_modified=1, target bfc00100, while the delay slot is in WAIT:
  - The delay slot bfc00014 is delivered.
  - The next request is bfc00100.
  - Repeat with PC_modified coinciding with the handoff: same sequence.
- exc_flush with exc_target=bfc00380 while in WAIT for bfc00020:
  - The late data_ok is dropped with no IF_ready.
  - The next request is bfc00380.
  - Repeat during REQ with addr_ok held 3 cycles low: addr stays bfc00020 until accepted.
- PC_modified_data=bfc00102:
  - After the delay slot, IF_ready=1 with IF_PC=bfc00102, exccode_out=04 and inst_out=0.
  - No req is issued for that PC.
- rst_n asserted mid-WAIT:
  - Outputs clear immediately.
  - After release, fetch restarts at bfc00000 and a stale data_ok during reset is ignored.
